// File: rtl/cordic_div_if.sv
// Operand/result bundle for the cordic_div iterative divider.
// start is a request pulse accepted only when the divider is idle; done is a one-cycle pulse with quotient valid from that edge and held until the next result.
interface cordic_div_if #(
    parameter int WIDTH = 16
);
    logic                    start;
    logic signed [WIDTH-1:0] numerator;
    logic signed [WIDTH-1:0] denominator;
    logic signed [WIDTH-1:0] quotient;
    logic                    done;

    modport master (
        output start, numerator, denominator,
        input  quotient, done
    );

    modport slave (
        input  start, numerator, denominator,
        output quotient, done
    );
endinterface

// File: rtl/cordic_div.sv
// Signed Q(WIDTH-FRAC_SZ).FRAC_SZ divider using a linear-mode CORDIC shift-and-subtract loop.
// One quotient bit per clock from MSB to LSB; exact truncation toward zero with saturation.
module cordic_div #(
    parameter int WIDTH   = 16,
    parameter int FRAC_SZ = 12
) (
    input  logic          clk,
    input  logic          reset,
    cordic_div_if.slave   bus,
    output logic [1:0]    o_state
);
    localparam int RW = WIDTH + FRAC_SZ + 1;
    localparam int CW = 2 * WIDTH + 1;
    localparam int BW = $clog2(WIDTH);

    localparam logic [WIDTH:0]   POS_MAG = {2'b00, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH:0]   NEG_MAG = {2'b01, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] Q_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] Q_MIN   = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, LOAD, ITER, FINISH} state_t;

    state_t            r_state;
    logic              r_sign;
    logic              r_num_neg;
    logic              r_div0;
    logic [WIDTH:0]    r_num_abs;
    logic [WIDTH:0]    r_den_abs;
    logic [RW-1:0]     r_res;
    logic [WIDTH:0]    r_z;
    logic [BW-1:0]     r_bit;
    logic [WIDTH-1:0]  r_quot;
    logic              r_done;

    logic [WIDTH:0]    w_num_ext;
    logic [WIDTH:0]    w_den_ext;
    logic [WIDTH:0]    w_num_abs;
    logic [WIDTH:0]    w_den_abs;
    logic [CW-1:0]     w_den_sh;
    logic              w_ge;
    logic [RW-1:0]     w_res_next;
    logic [WIDTH:0]    w_mag;
    logic [WIDTH-1:0]  w_q;

    // Magnitudes carry one extra bit so that -2^(WIDTH-1) stays representable.
    assign w_num_ext = {bus.numerator[WIDTH-1], bus.numerator};
    assign w_den_ext = {bus.denominator[WIDTH-1], bus.denominator};
    assign w_num_abs = bus.numerator[WIDTH-1]   ? -w_num_ext : w_num_ext;
    assign w_den_abs = bus.denominator[WIDTH-1] ? -w_den_ext : w_den_ext;

    // r_bit is the iteration exponent offset by FRAC_SZ, i.e. the z bit being decided.
    assign w_den_sh   = CW'(r_den_abs) << r_bit;
    assign w_ge       = CW'(r_res) >= w_den_sh;
    assign w_res_next = r_res - w_den_sh[RW-1:0];

    always_comb begin
        w_mag = r_z;
        if (r_sign) begin
            if (r_z > NEG_MAG) w_mag = NEG_MAG;
        end else begin
            if (r_z > POS_MAG) w_mag = POS_MAG;
        end
        if (r_div0)
            w_q = r_num_neg ? Q_MIN : Q_MAX;
        else
            w_q = WIDTH'(r_sign ? -w_mag : w_mag);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_sign    <= 1'b0;
            r_num_neg <= 1'b0;
            r_div0    <= 1'b0;
            r_num_abs <= '0;
            r_den_abs <= '0;
            r_res     <= '0;
            r_z       <= '0;
            r_bit     <= '0;
            r_quot    <= '0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_sign    <= bus.numerator[WIDTH-1] ^ bus.denominator[WIDTH-1];
                        r_num_neg <= bus.numerator[WIDTH-1];
                        r_div0    <= (bus.denominator == '0);
                        r_num_abs <= w_num_abs;
                        r_den_abs <= w_den_abs;
                        r_state   <= LOAD;
                    end
                end
                LOAD: begin
                    r_res   <= RW'(r_num_abs) << FRAC_SZ;
                    r_z     <= '0;
                    r_bit   <= BW'(WIDTH - 1);
                    r_state <= ITER;
                end
                ITER: begin
                    if (w_ge) begin
                        r_res <= w_res_next;
                        r_z   <= r_z | ((WIDTH+1)'(1) << r_bit);
                    end
                    if (r_bit == '0)
                        r_state <= FINISH;
                    else
                        r_bit <= r_bit - 1'b1;
                end
                FINISH: begin
                    r_quot  <= w_q;
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.quotient = r_quot;
    assign bus.done     = r_done;
    assign o_state      = r_state;
endmodule

// File: tb/tb_cordic_div.sv
// Directed-vector bench for cordic_div: table of Q4.12 divisions plus reset-abort and busy-start sequences.
module tb_cordic_div;
    localparam int WIDTH   = 16;
    localparam int FRAC_SZ = 12;
    localparam int NVEC    = 19;

    typedef struct {
        logic signed [15:0] num;
        logic signed [15:0] den;
        logic signed [15:0] exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] dbg_state;
    int         n_applied = 0;
    int         n_miss    = 0;
    logic [WIDTH-1:0] exp_q[$];
    vec_t       vecs[NVEC];

    cordic_div_if #(.WIDTH(WIDTH)) bus ();

    cordic_div #(.WIDTH(WIDTH), .FRAC_SZ(FRAC_SZ)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .o_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge; start is sampled on the following posedge (edge 0).
    task automatic run_op(input logic signed [15:0] num, input logic signed [15:0] den,
                          input logic signed [15:0] exp, input bit poke);
        bit got;
        int lat;
        logic signed [15:0] want;
        got = 1'b0;
        lat = 0;
        bus.start       = 1'b1;
        bus.numerator   = num;
        bus.denominator = den;
        exp_q.push_back(exp);
        @(negedge clk);
        bus.start       = 1'b0;
        bus.numerator   = 16'($urandom_range(0, 65535));
        bus.denominator = 16'($urandom_range(0, 65535));
        for (int k = 1; k <= 40 && !got; k++) begin
            @(negedge clk);
            if (poke && k == 5) begin
                bus.start       = 1'b1;
                bus.numerator   = 16'sd1;
                bus.denominator = 16'sd3;
            end
            if (poke && k == 6) bus.start = 1'b0;
            if (bus.done === 1'b1) begin
                got = 1'b1;
                lat = k;
            end
        end
        want = exp_q.pop_front();
        if (!got) begin
            n_applied++;
            n_miss++;
            $display("FAIL timeout: no done within 40 edges for %0d/%0d", num, den);
        end else begin
            check("latency", lat, 18);
            check($sformatf("quotient %0d/%0d", num, den), bus.quotient, want);
            @(negedge clk);
            check("done_width", {31'd0, bus.done}, 0);
            check("quotient_hold", bus.quotient, want);
        end
    endtask

    initial begin
        bit saw_done;
        vecs[0]  = '{16'sd4096,   16'sd2048,   16'sd8192};
        vecs[1]  = '{16'sd2048,   16'sd4096,   16'sd2048};
        vecs[2]  = '{-16'sd4096,  16'sd2048,  -16'sd8192};
        vecs[3]  = '{16'sd4096,  -16'sd2048,  -16'sd8192};
        vecs[4]  = '{-16'sd4096, -16'sd2048,   16'sd8192};
        vecs[5]  = '{16'sd6144,   16'sd2048,   16'sd12288};
        vecs[6]  = '{16'sd0,      16'sd2048,   16'sd0};
        vecs[7]  = '{16'sd1,      16'sd3,      16'sd1365};
        vecs[8]  = '{-16'sd1,     16'sd3,     -16'sd1365};
        vecs[9]  = '{16'sd4096,   16'sd0,      16'sd32767};
        vecs[10] = '{-16'sd4096,  16'sd0,     -16'sd32768};
        vecs[11] = '{16'sd0,      16'sd0,      16'sd32767};
        vecs[12] = '{16'sd32767,  16'sd1,      16'sd32767};
        vecs[13] = '{-16'sd32768, 16'sd1,     -16'sd32768};
        vecs[14] = '{16'sd32767,  16'sd32767,  16'sd4096};
        vecs[15] = '{-16'sd32768, -16'sd32768, 16'sd4096};
        vecs[16] = '{-16'sd32768, 16'sd32767, -16'sd4096};
        vecs[17] = '{16'sd1,     -16'sd32768,  16'sd0};
        vecs[18] = '{16'sd3,     -16'sd4096,  -16'sd3};

        // Clock/reset
        reset           = 1'b0;
        bus.start       = 1'b0;
        bus.numerator   = '0;
        bus.denominator = '0;
        repeat (3) @(negedge clk);
        check("reset_quotient", bus.quotient, 0);
        check("reset_done", {31'd0, bus.done}, 0);
        check("reset_state", {30'd0, dbg_state}, 0);
        reset = 1'b1;
        @(negedge clk);

        // Table vectors, each launched the cycle after the previous done
        for (int i = 0; i < NVEC; i++)
            run_op(vecs[i].num, vecs[i].den, vecs[i].exp, 1'b0);

        // Start pulsed while busy must be ignored, then a back-to-back start
        run_op(16'sd4096, 16'sd2048, 16'sd8192, 1'b1);
        run_op(16'sd2048, 16'sd4096, 16'sd2048, 1'b0);

        // Asynchronous reset mid-operation aborts without a done pulse
        bus.start       = 1'b1;
        bus.numerator   = 16'sd6144;
        bus.denominator = 16'sd2048;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("abort_quotient", bus.quotient, 0);
        check("abort_done", {31'd0, bus.done}, 0);
        check("abort_state", {30'd0, dbg_state}, 0);
        repeat (2) @(negedge clk);
        reset    = 1'b1;
        saw_done = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (bus.done !== 1'b0) saw_done = 1'b1;
        end
        check("no_done_after_abort", {31'd0, saw_done}, 0);
        check("idle_quotient_after_abort", bus.quotient, 0);

        run_op(16'sd6144, 16'sd2048, 16'sd12288, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
        $finish;
    end
endmodule
